// File: rtl/fault_injection_driver_pkg.sv
// fault_injection_driver_pkg: shared sizes, FSM state type and the injection-window rule
package fault_injection_driver_pkg;
    localparam int NUM_INJ = 346;
    localparam int CFG_W = 32;
    localparam int NUM_WORDS = (NUM_INJ + CFG_W - 1) / CFG_W;
    typedef enum logic [1:0] {IDLE, RUN, DONE} fidState_e;
    // A run that ends before injectCycle is reached never injects, whatever the mode.
    function automatic logic injectActive(
        input logic        mode,
        input logic [31:0] cnt,
        input logic [31:0] injectCycle,
        input logic [31:0] runCycles
    );
        return (injectCycle < runCycles) && (mode ? (cnt == injectCycle) : (cnt >= injectCycle));
    endfunction
endpackage

// File: rtl/fault_injection_driver_if.sv
// fault_injection_driver_if: mask-word configuration channel
interface fault_injection_driver_if #(
    parameter int CFG_W = fault_injection_driver_pkg::CFG_W
);
    logic             cfg_valid;
    logic             cfg_ready;
    logic             cfg_clear;
    logic [CFG_W-1:0] cfg_data;
    modport master(output cfg_valid, cfg_data, cfg_clear, input cfg_ready);
    modport slave(input cfg_valid, cfg_data, cfg_clear, output cfg_ready);
endinterface

// File: rtl/fid_mask_loader.sv
// fid_mask_loader: word-indexed fault mask register with load index and completeness flag
module fid_mask_loader
    import fault_injection_driver_pkg::*;
#(
    parameter int NUM_INJ = fault_injection_driver_pkg::NUM_INJ,
    parameter int CFG_W   = fault_injection_driver_pkg::CFG_W
) (
    input  logic               clk,
    input  logic               n_reset,
    input  logic               enable,
    input  logic               cfgValid,
    input  logic               cfgClear,
    input  logic [CFG_W-1:0]   cfgData,
    output logic [NUM_INJ-1:0] mask,
    output logic [NUM_INJ-1:0] maskNext,
    output logic               maskValid
);
    localparam int WORDS = (NUM_INJ + CFG_W - 1) / CFG_W;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    logic [IW-1:0]    index;
    logic [IW-1:0]    indexNext;
    logic [WORDS-1:0] wordHit;
    logic             clear;
    logic             write;
    logic             lastWord;
    logic             maskValidNext;
    assign clear = enable && cfgClear;
    assign write = enable && cfgValid && !clear;
    assign lastWord = (index == IW'(WORDS - 1));
    assign wordHit = write ? (WORDS'(1) << index) : '0;
    // Bits of the last word beyond NUM_INJ-1 have no mask bit and simply drop out here.
    for (genvar b = 0; b < NUM_INJ; b++) begin : g_bit
        assign maskNext[b] = clear ? 1'b0 : (wordHit[b / CFG_W] ? cfgData[b % CFG_W] : mask[b]);
    end
    assign indexNext = clear ? '0 : (write ? (lastWord ? '0 : index + 1'b1) : index);
    assign maskValidNext = clear ? 1'b0 : (maskValid || (write && lastWord));
    // Mask, word index and completeness flag; changes only when enabled (IDLE).
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            mask      <= '0;
            index     <= '0;
            maskValid <= 1'b0;
        end else begin
            mask      <= maskNext;
            index     <= indexNext;
            maskValid <= maskValidNext;
        end
    end
endmodule

// File: rtl/fault_injection_driver.sv
// fault_injection_driver: loads a fault mask and drives it into the CUT over a timed run
module fault_injection_driver
    import fault_injection_driver_pkg::*;
#(
    parameter int NUM_INJ = fault_injection_driver_pkg::NUM_INJ,
    parameter int CFG_W   = fault_injection_driver_pkg::CFG_W
) (
    input  logic                     clk,
    input  logic                     n_reset,
    fault_injection_driver_if.slave  cfg,
    input  logic                     start,
    input  logic                     mode,
    input  logic [31:0]              inject_cycle,
    input  logic [31:0]              run_cycles,
    input  logic                     abort,
    output logic [NUM_INJ-1:0]       injectionVector,
    output logic                     busy,
    output logic                     done,
    output logic                     mask_valid,
    output logic                     start_err
);
    fidState_e          state;
    fidState_e          stateNext;
    logic [31:0]        cnt;
    logic [31:0]        cntNext;
    logic               modeLat;
    logic               modeNext;
    logic [31:0]        injectCycleLat;
    logic [31:0]        injectCycleNext;
    logic [31:0]        runCyclesLat;
    logic [31:0]        runCyclesNext;
    logic               startErrNext;
    logic [NUM_INJ-1:0] mask;
    logic [NUM_INJ-1:0] maskNext;
    logic [NUM_INJ-1:0] vectorNext;
    fid_mask_loader #(.NUM_INJ(NUM_INJ), .CFG_W(CFG_W)) u_loader (
        .clk       (clk),
        .n_reset   (n_reset),
        .enable    (state == IDLE),
        .cfgValid  (cfg.cfg_valid),
        .cfgClear  (cfg.cfg_clear),
        .cfgData   (cfg.cfg_data),
        .mask      (mask),
        .maskNext  (maskNext),
        .maskValid (mask_valid)
    );
    assign cfg.cfg_ready = (state == IDLE);
    assign busy = (state == RUN);
    assign done = (state == DONE);
    // Next state, run counter, parameter latch and the registered injection vector.
    always_comb begin
        stateNext = state;
        cntNext = cnt;
        modeNext = modeLat;
        injectCycleNext = injectCycleLat;
        runCyclesNext = runCyclesLat;
        startErrNext = 1'b0;
        case (state)
            IDLE: begin
                if (start && mask_valid) begin
                    stateNext = RUN;
                    cntNext = '0;
                    modeNext = mode;
                    injectCycleNext = inject_cycle;
                    runCyclesNext = run_cycles;
                end else if (start) begin
                    startErrNext = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    stateNext = IDLE;
                end else if (runCyclesLat == 32'd0 || cnt == runCyclesLat - 32'd1) begin
                    stateNext = DONE;
                end else begin
                    cntNext = cnt + 32'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
        // On the starting edge a word may land in the mask at the same time, so take the updated mask.
        vectorNext = (stateNext == RUN && injectActive(modeNext, cntNext, injectCycleNext, runCyclesNext))
                   ? ((state == IDLE) ? maskNext : mask) : '0;
    end
    // State and run registers; reset clears the injection vector without waiting for a clock.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state           <= IDLE;
            cnt             <= '0;
            modeLat         <= 1'b0;
            injectCycleLat  <= '0;
            runCyclesLat    <= '0;
            injectionVector <= '0;
            start_err       <= 1'b0;
        end else begin
            state           <= stateNext;
            cnt             <= cntNext;
            modeLat         <= modeNext;
            injectCycleLat  <= injectCycleNext;
            runCyclesLat    <= runCyclesNext;
            injectionVector <= vectorNext;
            start_err       <= startErrNext;
        end
    end
endmodule

// File: doc/fault_injection_driver.md
FAULT_INJECTION_DRIVER -- requirements
Module: fault_injection_driver

Interface
REQ-001 Parameter NUM_INJ, default 346: width of the injection vector driven into the circuit under test.
REQ-002 Parameter CFG_W, default 32: configuration word width; NUM_WORDS = ceil(NUM_INJ/CFG_W) = 11.
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  sole clock; all state on rising edge.
REQ-005 n_reset  in  1  asynchronous active-low reset.
REQ-006 cfg_valid  in  1  mask word offered.
REQ-007 cfg_ready  out  1  mask word accepted when cfg_valid & cfg_ready.
REQ-008 cfg_data  in  CFG_W  mask word; word i maps to mask bits [i*CFG_W +: CFG_W].
REQ-009 cfg_clear  in  1  zero mask and word index.
REQ-010 start  in  1  one-cycle request to begin a run.
REQ-011 mode  in  1  0 = permanent (stuck from inject_cycle to end), 1 = transient (single cycle).
REQ-012 inject_cycle  in  32  run-relative cycle at which injection begins.
REQ-013 run_cycles  in  32  run length in cycles.
REQ-014 abort  in  1  terminate run immediately.
REQ-015 injectionVector  out  NUM_INJ  per-flip-flop fault enable into the CUT, registered.
REQ-016 busy  out  1  high in RUN.
REQ-017 done  out  1  one-cycle pulse at normal run completion.
REQ-018 mask_valid  out  1  all NUM_WORDS words loaded since last clear/reset.
REQ-019 start_err  out  1  one-cycle pulse when start rejected.

Function
REQ-020 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 cfg_ready SHALL be 1 only in IDLE; mask and word index SHALL be unchanged outside IDLE.
REQ-022 Each accepted word SHALL write mask slice at current index, then index increments; bits above NUM_INJ-1 in last word discarded.
REQ-023 Acceptance of word NUM_WORDS-1 SHALL set mask_valid and wrap index to 0; further words overwrite from word 0 with mask_valid held at 1.
REQ-024 cfg_clear in IDLE SHALL zero mask, index and mask_valid next cycle; cfg_clear takes priority over a simultaneous accepted word.
REQ-025 start in IDLE with mask_valid=1 SHALL latch mode, inject_cycle, run_cycles, clear cycle counter cnt to 0, enter RUN next cycle.
REQ-026 start in IDLE with mask_valid=0 SHALL pulse start_err for one cycle and remain IDLE; start in RUN or DONE SHALL be ignored without start_err.
REQ-027 In RUN, cnt (32-bit) SHALL increment each cycle; RUN cycle k has cnt=k.
REQ-028 injectionVector during RUN cycle k SHALL equal mask when (mode=0 and k>=inject_cycle) or (mode=1 and k==inject_cycle), else all-zero.
REQ-029 RUN SHALL last exactly run_cycles cycles then enter DONE; run_cycles=0 SHALL spend one RUN cycle with zero injection.
REQ-030 DONE SHALL last one cycle with done=1, injectionVector zero, then return to IDLE.
REQ-031 inject_cycle>=run_cycles SHALL yield no injection for the whole run.
REQ-032 abort in RUN SHALL zero injectionVector and enter IDLE next cycle without done; abort outside RUN ignored; abort wins over a simultaneous run end.
REQ-033 injectionVector SHALL be zero in IDLE and DONE.

Reset
REQ-034 On n_reset low: state IDLE, mask, index, cnt, latched parameters zero; injectionVector zero, busy 0, done 0, mask_valid 0, start_err 0, cfg_ready 1 after release.
REQ-035 Reset asserted mid-RUN SHALL zero injectionVector asynchronously.

Structure
REQ-036 Shared package SHALL hold state enum, NUM_INJ, CFG_W, NUM_WORDS.
REQ-037 One sub-module, fid_mask_loader, SHALL implement the word-indexed mask register, index and mask_valid; FSM, counter and gating stay top-level.

Verification
REQ-038 Load 11 words of 0xFFFFFFFF, mode=0, inject_cycle=3, run_cycles=8 -> vector zero cycles 0-2, all-ones (346 bits) cycles 3-7, done pulse one cycle later.
REQ-039 Mask bit 0 only, mode=1, inject_cycle=5, run_cycles=10 -> vector 1 only in RUN cycle 5, zero elsewhere, busy high 10 cycles.
REQ-040 start after 10 words only -> start_err pulse, state IDLE; 11th word then start -> run proceeds.
REQ-041 abort at RUN cycle 4 of mode=0 inject_cycle=2 run_cycles=20 -> vector zero next cycle, no done, cfg_ready 1.
REQ-042 n_reset low at RUN cycle 6 -> vector zero immediately, mask_valid 0, start after release -> start_err.
REQ-043 run_cycles=0 and inject_cycle=0xFFFFFFFF, run_cycles=4 -> no injection at any cycle, done each run; cfg_clear with simultaneous cfg_valid -> mask zero, mask_valid 0.
